// File: rtl/fpu_norm_prep.sv
// fpu_norm_prep: LZC + EMIN clamp prep stage ahead of the FPU left shifter.
// Define FPU_NORM_PREP_PIPE_EN for an extra input register stage (latency 2).
module fpu_norm_prep #(
    parameter int DATA_WIDTH  = 77,
    parameter int SHAMT_WIDTH = 7,
    parameter int EXP_WIDTH   = 13,
    parameter int EMIN        = -1022
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_WIDTH-1:0]  mant_i,
    input  logic [EXP_WIDTH-1:0]   exp_i,
    input  logic                   sign_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  mant_o,
    output logic [SHAMT_WIDTH-1:0] shamt_o,
    output logic [EXP_WIDTH-1:0]   exp_o,
    output logic                   sign_o,
    output logic                   zero_o
);
    localparam logic signed [EXP_WIDTH:0] EMIN_W = (EXP_WIDTH+1)'(EMIN);

    logic                   s2_valid_q, s2_valid_d, s2_accept;
    logic [DATA_WIDTH-1:0]  mant_q;
    logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d, lzc;
    logic [EXP_WIDTH-1:0]   exp_q, exp_d;
    logic                   sign_q, zero_q, zero_d;
    logic                   src_valid, src_sign;
    logic [DATA_WIDTH-1:0]  src_mant;
    logic [EXP_WIDTH-1:0]   src_exp;
    logic signed [EXP_WIDTH:0] e_w, lzc_w, diff_w, over_w, sh_w, expo_w;

    assign s2_accept = !s2_valid_q || out_ready_i;

`ifdef FPU_NORM_PREP_PIPE_EN
    logic                  s1_valid_q, s1_sign_q, in_fire;
    logic [DATA_WIDTH-1:0] s1_mant_q;
    logic [EXP_WIDTH-1:0]  s1_exp_q;

    assign in_ready_o = !s1_valid_q || s2_accept;
    assign in_fire    = in_valid_i && in_ready_o;
    assign src_valid  = s1_valid_q;
    assign src_mant   = s1_mant_q;
    assign src_exp    = s1_exp_q;
    assign src_sign   = s1_sign_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_exp_q   <= '0;
            s1_sign_q  <= 1'b0;
        end else begin
            s1_valid_q <= !flush_i && (in_fire || (s1_valid_q && !s2_accept));
            if (in_fire) begin
                s1_mant_q <= mant_i;
                s1_exp_q  <= exp_i;
                s1_sign_q <= sign_i;
            end
        end
    end
`else
    assign in_ready_o = s2_accept;
    assign src_valid  = in_valid_i;
    assign src_mant   = mant_i;
    assign src_exp    = exp_i;
    assign src_sign   = sign_i;
`endif

    // Last assignment wins, so the highest set bit determines the count.
    always_comb begin
        lzc = SHAMT_WIDTH'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++)
            if (src_mant[i]) lzc = SHAMT_WIDTH'(DATA_WIDTH - 1 - i);
    end

    assign e_w    = {src_exp[EXP_WIDTH-1], src_exp};
    assign lzc_w  = {{(EXP_WIDTH+1-SHAMT_WIDTH){1'b0}}, lzc};
    assign diff_w = e_w - lzc_w;
    assign over_w = e_w - EMIN_W;
    assign zero_d = ~|src_mant;

    // Shifting past EMIN would underflow, so stop at EMIN and leave a subnormal.
    assign shamt_d = zero_d ? '0 :
                     diff_w >= EMIN_W ? lzc :
                     e_w > EMIN_W ? over_w[SHAMT_WIDTH-1:0] : '0;
    assign sh_w    = {{(EXP_WIDTH+1-SHAMT_WIDTH){1'b0}}, shamt_d};
    assign expo_w  = e_w - sh_w;
    assign exp_d   = zero_d ? EMIN_W[EXP_WIDTH-1:0] : expo_w[EXP_WIDTH-1:0];

    assign s2_valid_d = !flush_i && (s2_accept ? src_valid : s2_valid_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            mant_q     <= '0;
            shamt_q    <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_accept && src_valid) begin
                mant_q  <= src_mant;
                shamt_q <= shamt_d;
                exp_q   <= exp_d;
                sign_q  <= src_sign;
                zero_q  <= zero_d;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign mant_o      = mant_q;
    assign shamt_o     = shamt_q;
    assign exp_o       = exp_q;
    assign sign_o      = sign_q;
    assign zero_o      = zero_q;
endmodule

// File: tb/tb_fpu_norm_prep.sv
// tb_fpu_norm_prep: directed vector table plus handshake, flush and reset sequences.
module tb_fpu_norm_prep;
    localparam int DW = 77;
    localparam int EMIN = -1022;
`ifdef FPU_NORM_PREP_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] mant_i = '0;
    logic [12:0]   exp_i = '0;
    logic          sign_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [DW-1:0] mant_o;
    logic [6:0]    shamt_o;
    logic [12:0]   exp_o;
    logic          sign_o;
    logic          zero_o;

    int checks = 0;
    int errors = 0;

    fpu_norm_prep dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mant_i(mant_i), .exp_i(exp_i), .sign_i(sign_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .mant_o(mant_o), .shamt_o(shamt_o), .exp_o(exp_o),
        .sign_o(sign_o), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] mant;
        logic [12:0]   exp;
        logic          sign;
        logic [6:0]    shamt;
        logic [12:0]   exp_o;
        logic          zero;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic chk_out(input string name, input vec_t v);
        chk({name, ".mant"}, 128'(mant_o), 128'(v.mant));
        chk({name, ".shamt"}, 128'(shamt_o), 128'(v.shamt));
        chk({name, ".exp"}, 128'(exp_o), 128'(v.exp_o));
        chk({name, ".sign"}, 128'(sign_o), 128'(v.sign));
        chk({name, ".zero"}, 128'(zero_o), 128'(v.zero));
    endtask

    task automatic drive(input vec_t v);
        mant_i = v.mant;
        exp_i  = v.exp;
        sign_i = v.sign;
    endtask

    // One isolated transfer with an idle downstream; checks latency and fields.
    task automatic send_one(input string name, input vec_t v);
        int n;
        @(negedge clk_i);
        drive(v);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        #1 chk({name, ".ready"}, 128'(in_ready_o), 128'(1));
        @(negedge clk_i);
        in_valid_i = 1'b0;
        n = 1;
        while (!out_valid_o && n < 8) begin
            @(negedge clk_i);
            n++;
        end
        chk({name, ".latency"}, 128'(n), 128'(LAT));
        chk_out(name, v);
    endtask

    function automatic vec_t ref_vec(input logic [DW-1:0] m, input int e, input logic s);
        vec_t r;
        int lz, sh, eo;
        lz = 0;
        while (lz < DW && !m[DW-1-lz]) lz++;
        if (lz == DW) begin sh = 0; eo = EMIN; end
        else if (e - lz >= EMIN) begin sh = lz; eo = e - lz; end
        else if (e > EMIN) begin sh = e - EMIN; eo = EMIN; end
        else begin sh = 0; eo = e; end
        r.mant = m; r.exp = 13'(e); r.sign = s;
        r.shamt = 7'(sh); r.exp_o = 13'(eo); r.zero = (lz == DW);
        return r;
    endfunction

    vec_t tp[20];
    vec_t bp[5];
    vec_t va, vx;

    initial begin
        int sent, recv, k;
        logic saw_block;
        logic [95:0] rnd;
        tbl[0]  = '{77'h1 << 70, 13'(5), 1'b0, 7'd6, 13'(-1), 1'b0};
        tbl[1]  = '{77'h1 << 10, 13'(EMIN+3), 1'b0, 7'd3, 13'(EMIN), 1'b0};
        tbl[2]  = '{77'h1 << 10, 13'(EMIN-2), 1'b1, 7'd0, 13'(EMIN-2), 1'b0};
        tbl[3]  = '{77'h0, 13'(100), 1'b1, 7'd0, 13'(EMIN), 1'b1};
        tbl[4]  = '{77'h1 << 76, 13'(0), 1'b0, 7'd0, 13'(0), 1'b0};
        tbl[5]  = '{77'h1, 13'(100), 1'b1, 7'd76, 13'(24), 1'b0};
        tbl[6]  = '{{1'b1, 76'h5}, 13'(EMIN), 1'b0, 7'd0, 13'(EMIN), 1'b0};
        tbl[7]  = '{77'h1 << 75, 13'(EMIN), 1'b0, 7'd0, 13'(EMIN), 1'b0};
        tbl[8]  = '{77'h1 << 75, 13'(EMIN+1), 1'b1, 7'd1, 13'(EMIN), 1'b0};
        tbl[9]  = '{{77{1'b1}}, 13'(-5), 1'b1, 7'd0, 13'(-5), 1'b0};
        tbl[10] = '{77'h0, 13'(-4000), 1'b0, 7'd0, 13'(EMIN), 1'b1};
        tbl[11] = '{77'h1, 13'(4095), 1'b0, 7'd76, 13'(4019), 1'b0};

        repeat (2) @(negedge clk_i);
        chk("rst.valid", 128'(out_valid_o), 128'(0));
        chk("rst.fields", {mant_o, shamt_o, exp_o, sign_o, zero_o}, 128'(0));
        rst_ni = 1'b1;
        #1 chk("rst.ready", 128'(in_ready_o), 128'(1));

        for (int i = 0; i < 12; i++) send_one($sformatf("vec%0d", i), tbl[i]);

        // Backpressure: five entries with downstream stalled on cycles 3..6.
        for (int i = 0; i < 5; i++)
            bp[i] = '{{1'b1, 76'(i + 1)}, 13'(200 + i), 1'(i), 7'd0, 13'(200 + i), 1'b0};
        sent = 0; recv = 0; saw_block = 1'b0;
        for (int c = 0; c < 30 && recv < 5; c++) begin
            @(negedge clk_i);
            out_ready_i = !(c >= 3 && c <= 6);
            in_valid_i  = sent < 5;
            if (sent < 5) drive(bp[sent]);
            #1;
            if (in_valid_i && !in_ready_o) saw_block = 1'b1;
            if (out_valid_o && !out_ready_i) chk_out($sformatf("bp.hold%0d", c), bp[recv]);
            if (out_valid_o && out_ready_i) begin
                chk_out($sformatf("bp.out%0d", recv), bp[recv]);
                recv++;
            end
            if (in_valid_i && in_ready_o) sent++;
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("bp.blocked", 128'(saw_block), 128'(1));
        chk("bp.count", 128'(recv), 128'(5));
        @(negedge clk_i);
        #1 chk("bp.drained", 128'(out_valid_o), 128'(0));

        // Flush with entries in flight, input offered in the flush cycle is dropped.
        @(negedge clk_i);
        out_ready_i = 1'b0; in_valid_i = 1'b1; drive(tbl[0]);
        @(negedge clk_i);
        drive(tbl[5]);
        @(negedge clk_i);
        flush_i = 1'b1; drive(tbl[9]);
        @(negedge clk_i);
        flush_i = 1'b0; in_valid_i = 1'b0;
        #1 chk("flush.valid1", 128'(out_valid_o), 128'(0));
        @(negedge clk_i);
        #1 chk("flush.valid2", 128'(out_valid_o), 128'(0));
        send_one("flush.next", tbl[8]);

        // Asynchronous reset while an entry is stalled at the output.
        @(negedge clk_i);
        out_ready_i = 1'b0; in_valid_i = 1'b1; drive(tbl[0]);
        @(negedge clk_i);
        drive(tbl[5]);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1 chk("arst.pre", 128'(out_valid_o), 128'(1));
        #2 rst_ni = 1'b0;
        #1 chk("arst.valid", 128'(out_valid_o), 128'(0));
        chk("arst.fields", {mant_o, shamt_o, exp_o, sign_o, zero_o}, 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 chk("arst.ready", 128'(in_ready_o), 128'(1));
        send_one("arst.next", tbl[11]);

        // Back-to-back stream with out_ready held high.
        for (int i = 0; i < 20; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            tp[i] = ref_vec(rnd[DW-1:0] >> $urandom_range(0, 80),
                            int'($urandom_range(0, 1400)) - 1200, 1'($urandom));
        end
        for (int c = 0; c < 20 + LAT + 2; c++) begin
            @(negedge clk_i);
            out_ready_i = 1'b1;
            in_valid_i  = c < 20;
            if (c < 20) drive(tp[c]);
            #1;
            if (c < 20) chk($sformatf("tp.ready%0d", c), 128'(in_ready_o), 128'(1));
            k = c - LAT;
            chk($sformatf("tp.valid%0d", c), 128'(out_valid_o), 128'(k >= 0 && k < 20));
            if (k >= 0 && k < 20) chk_out($sformatf("tp.out%0d", k), tp[k]);
        end
        in_valid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
